lfsr_rng_arbiter: RTL and testbench

- Shares one internal LFSR random-number source between N_REQ requesters using round-robin arbitration.
- Each granted request receives one unique word, and the LFSR advances exactly one step per delivered word.
- Supports runtime reseeding and a post-seed warm-up phase, during which no words are delivered.
- Sits between the shared PRNG datapath and consumers such as test-pattern generators and scramblers.

---
 rtl/lfsr_rng_arbiter.sv | 125 ++++++++++++
 tb/tb_lfsr_rng_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng_arbiter.sv
// Shared LFSR random-number source, handed out one word per grant to N_REQ requesters
// in round-robin order. Reseeding restarts a warm-up phase during which nothing is granted.
module lfsr_rng_arbiter #(
  parameter int              WIDTH         = 32,
  parameter logic [WIDTH-1:0] SEED         = WIDTH'(34489738),
  parameter logic [WIDTH-1:0] TAP          = WIDTH'(32'h80000032),
  parameter int              N_REQ         = 4,
  parameter int              WARMUP_CYCLES = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             rnd_valid,
  output logic [WIDTH-1:0] rnd_data,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_value,
  output logic             busy
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WARMUP_CYCLES);

  localparam logic [0:0] ST_WARMUP = 1'b0;
  localparam logic [0:0] ST_SERVE  = 1'b1;
  // Where reset and reseed land: skip WARMUP entirely when no warm-up is configured.
  localparam logic [0:0] ST_START  = (WARMUP_CYCLES > 0) ? ST_WARMUP : ST_SERVE;

  logic [0:0]       fsm_q, fsm_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d, lfsr_step;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign lfsr_step = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAP)};

  // Round-robin pick: lowest request at or above ptr, else lowest request overall.
  logic [N_REQ-1:0] mask_hi, req_hi;
  logic [PW-1:0]    hi_idx, lo_idx, win_idx, ptr_nxt;
  logic             hi_found;

  assign mask_hi = ~((N_REQ'(1) << ptr_q) - N_REQ'(1));
  assign req_hi  = req & mask_hi;

  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_hi[i]) begin
        hi_found = 1'b1;
        hi_idx   = PW'(i);
      end
      if (req[i]) lo_idx = PW'(i);
    end
  end

  assign win_idx = hi_found ? hi_idx : lo_idx;
  assign ptr_nxt = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);

  always_comb begin
    fsm_d   = fsm_q;
    lfsr_d  = lfsr_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    valid_d = 1'b0;
    data_d  = data_q;
    if (seed_load) begin
      lfsr_d = (seed_value == '0) ? SEED : seed_value;
      cnt_d  = CNT_INIT;
      fsm_d  = ST_START;
    end else begin
      case (fsm_q)
        ST_WARMUP: begin
          lfsr_d = lfsr_step;
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q <= CW'(1)) fsm_d = ST_SERVE;
        end
        default: begin
          if (|req) begin
            gnt_d   = N_REQ'(1) << win_idx;
            valid_d = 1'b1;
            data_d  = lfsr_q;
            lfsr_d  = lfsr_step;
            ptr_d   = ptr_nxt;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fsm_q   <= ST_START;
      lfsr_q  <= SEED;
      ptr_q   <= '0;
      cnt_q   <= CNT_INIT;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      lfsr_q  <= lfsr_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign gnt       = gnt_q;
  assign rnd_valid = valid_q;
  assign rnd_data  = data_q;
  assign busy      = (fsm_q == ST_WARMUP);

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!n_rst) $onehot0(gnt_q));
  a_valid_gnt   : assert property (@(posedge clk) disable iff (!n_rst) valid_q == (|gnt_q));
  a_lfsr_nz     : assert property (@(posedge clk) disable iff (!n_rst) lfsr_q != '0);

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Bench for lfsr_rng_arbiter: an 8-bit no-warm-up instance tracked by a cycle model
// plus literal vectors, and a default-parameter instance checked for warm-up and reseed.
module tb_lfsr_rng_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] SEED32 = 32'd34489738;
  localparam logic [31:0] TAP32  = 32'h80000032;

  logic       n_rst8, seed_load8, rnd_valid8, busy8;
  logic [3:0] req8, gnt8;
  logic [7:0] rnd_data8, seed_value8;

  logic        n_rstd, seed_loadd, rnd_validd, busyd;
  logic [3:0]  reqd, gntd;
  logic [31:0] rnd_datad, seed_valued;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  lfsr_rng_arbiter #(
    .WIDTH(8), .SEED(8'h01), .TAP(8'hB8), .N_REQ(4), .WARMUP_CYCLES(0)
  ) dut8 (
    .clk(clk), .n_rst(n_rst8), .req(req8), .gnt(gnt8), .rnd_valid(rnd_valid8),
    .rnd_data(rnd_data8), .seed_load(seed_load8), .seed_value(seed_value8), .busy(busy8)
  );

  lfsr_rng_arbiter dutd (
    .clk(clk), .n_rst(n_rstd), .req(reqd), .gnt(gntd), .rnd_valid(rnd_validd),
    .rnd_data(rnd_datad), .seed_load(seed_loadd), .seed_value(seed_valued), .busy(busyd)
  );

  function automatic logic [31:0] lfsr_ref(input logic [31:0] s, input logic [31:0] tap,
                                           input int w);
    logic [31:0] mask;
    logic        fb;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    fb   = ^(s & tap & mask);
    return ((s << 1) | {31'd0, fb}) & mask;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out8(input string tag, input logic [3:0] g, input logic v,
                          input logic [7:0] d);
    chk({tag, "_gnt"},   64'(gnt8),       64'(g));
    chk({tag, "_valid"}, 64'(rnd_valid8), 64'(v));
    chk({tag, "_data"},  64'(rnd_data8),  64'(d));
  endtask

  task automatic chk_outd(input string tag, input logic [3:0] g, input logic v,
                          input logic [31:0] d);
    chk({tag, "_gnt"},   64'(gntd),       64'(g));
    chk({tag, "_valid"}, 64'(rnd_validd), 64'(v));
    chk({tag, "_data"},  64'(rnd_datad),  64'(d));
  endtask

  // Cycle model of the 8-bit instance, written from the arbitration rules.
  logic [7:0] m_state = 8'h01;
  logic [7:0] m_data  = 8'h00;
  logic [3:0] m_gnt   = 4'h0;
  logic       m_valid = 1'b0;
  int         m_ptr   = 0;

  always @(posedge clk or negedge n_rst8) begin
    int win;
    if (!n_rst8) begin
      m_state = 8'h01; m_ptr = 0; m_gnt = 4'h0; m_valid = 1'b0; m_data = 8'h00;
    end else if (seed_load8) begin
      m_state = (seed_value8 == 8'h00) ? 8'h01 : seed_value8;
      m_gnt   = 4'h0;
      m_valid = 1'b0;
    end else if (req8 != 4'h0) begin
      win = -1;
      for (int k = 0; k < 4; k++) begin
        if (win < 0 && ((req8 >> ((m_ptr + k) % 4)) & 4'd1) != 4'd0) win = (m_ptr + k) % 4;
      end
      m_gnt   = 4'b0001 << win;
      m_valid = 1'b1;
      m_data  = m_state;
      m_state = 8'(lfsr_ref({24'd0, m_state}, 32'h0000_00B8, 8));
      m_ptr   = (win + 1) % 4;
    end else begin
      m_gnt   = 4'h0;
      m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("model_gnt",   64'(gnt8),       64'(m_gnt));
    chk("model_valid", 64'(rnd_valid8), 64'(m_valid));
    chk("model_data",  64'(rnd_data8),  64'(m_data));
    chk("busy8_low",   64'(busy8),      64'(1'b0));
    chk("d_onehot0",   64'($onehot0(gntd)), 64'(1'b1));
    chk("d_valid_gnt", 64'(rnd_validd), 64'(|gntd));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ref_s;
    logic [3:0]  gseq[5];
    n_rst8 = 1'b0; n_rstd = 1'b0;
    req8 = 4'h0; reqd = 4'h0;
    seed_load8 = 1'b0; seed_loadd = 1'b0;
    seed_value8 = 8'h00; seed_valued = 32'h0;
    repeat (2) tick();

    chk_out8("rst8", 4'h0, 1'b0, 8'h00);
    chk_outd("rstd", 4'h0, 1'b0, 32'h0);
    chk("rstd_busy", 64'(busyd), 64'(1'b1));

    // Default instance: 16 warm-up cycles, then the 16-times-stepped seed.
    n_rstd = 1'b1; reqd = 4'hF;
    chk("wu_busy_0", 64'(busyd), 64'(1'b1));
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("wu_busy", 64'(busyd), 64'(1'b1));
      chk("wu_gnt",  64'(gntd),  64'(4'h0));
    end
    tick();
    chk("wu_end_busy", 64'(busyd), 64'(1'b0));
    chk("wu_end_gnt",  64'(gntd),  64'(4'h0));
    ref_s = SEED32;
    repeat (16) ref_s = lfsr_ref(ref_s, TAP32, 32);
    tick(); chk_outd("wu_first", 4'b0001, 1'b1, ref_s);
    ref_s = lfsr_ref(ref_s, TAP32, 32);
    tick(); chk_outd("wu_second", 4'b0010, 1'b1, ref_s);

    // Reseed held three cycles: warm-up restarts from the last load.
    seed_loadd = 1'b1; seed_valued = 32'hDEAD_BEEF;
    repeat (3) begin
      tick();
      chk("rs_busy", 64'(busyd), 64'(1'b1));
      chk("rs_gnt",  64'(gntd),  64'(4'h0));
    end
    seed_loadd = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("rs_wu_busy", 64'(busyd), 64'(1'b1));
    end
    tick(); chk("rs_wu_end", 64'(busyd), 64'(1'b0));
    ref_s = 32'hDEAD_BEEF;
    repeat (16) ref_s = lfsr_ref(ref_s, TAP32, 32);
    tick(); chk_outd("rs_first", 4'b0100, 1'b1, ref_s);
    reqd = 4'h0;

    // Single requester: 01, 02, 04, then idle holds the last word.
    n_rst8 = 1'b1; req8 = 4'b0001;
    exp_q = '{8'h01, 8'h02, 8'h04};
    while (exp_q.size() > 0) begin
      tick();
      chk_out8("t1", 4'b0001, 1'b1, exp_q.pop_front());
    end
    req8 = 4'h0;
    tick(); chk_out8("t1_idle", 4'h0, 1'b0, 8'h04);

    // All requesting: strict rotation with the LFSR sequence.
    n_rst8 = 1'b0; #1;
    chk_out8("rst_pulse", 4'h0, 1'b0, 8'h00);
    tick(); n_rst8 = 1'b1; req8 = 4'hF;
    gseq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out8("t2", gseq[i], 1'b1, exp_q.pop_front());
    end

    // Asynchronous reset mid-cycle clears outputs at once; service restarts at requester 0.
    #2; n_rst8 = 1'b0; #1;
    chk_out8("async_rst", 4'h0, 1'b0, 8'h00);
    tick(); n_rst8 = 1'b1;
    tick(); chk_out8("post_rst0", 4'b0001, 1'b1, 8'h01);
    tick(); chk_out8("post_rst1", 4'b0010, 1'b1, 8'h02);

    // Requesters 1 and 3 only alternate.
    n_rst8 = 1'b0;
    tick(); n_rst8 = 1'b1; req8 = 4'b1010;
    gseq = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0000};
    exp_q = '{8'h01, 8'h02, 8'h04, 8'h08};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out8("t3", gseq[i], 1'b1, exp_q.pop_front());
    end

    // Reseed wins over a same-cycle request; zero seed falls back to SEED.
    seed_load8 = 1'b1; seed_value8 = 8'h80; req8 = 4'b0001;
    tick(); chk_out8("seed_edge", 4'h0, 1'b0, 8'h08);
    seed_load8 = 1'b0;
    tick(); chk_out8("seed_w0", 4'b0001, 1'b1, 8'h80);
    tick(); chk_out8("seed_w1", 4'b0001, 1'b1, 8'h01);
    seed_load8 = 1'b1; seed_value8 = 8'h00;
    tick(); chk_out8("zseed_edge", 4'h0, 1'b0, 8'h01);
    seed_load8 = 1'b0;
    tick(); chk_out8("zseed_w0", 4'b0001, 1'b1, 8'h01);
    tick(); chk_out8("zseed_w1", 4'b0001, 1'b1, 8'h02);

    // Mixed request patterns with occasional reseeds, checked against the model.
    for (int i = 0; i < 60; i++) begin
      req8        = 4'($urandom_range(0, 15));
      seed_load8  = ($urandom_range(0, 9) == 0);
      seed_value8 = 8'($urandom_range(0, 255));
      tick();
    end
    seed_load8 = 1'b0;
    req8 = 4'h0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
